uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- UART receive path; counterpart of the existing TRANSMITTER, sharing the same BaudRateGen 16x oversampling tick and frame format.
- Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit (even/odd), stop bit(s).
- Recovers bytes from the serial line, flags parity and framing errors, and pulses RX_DONE once per byte so it can drive an RX FIFO write enable directly.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- STOP_BIT_TICKS, 16, oversampling ticks in the stop field (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- PARITY_EN  in  1  1 = a parity bit follows the data bits.
- PARITY_MODE  in  1  0 = even, 1 = odd.
- RX_BR_TICKS  in  1  one-CLK-wide 16x baud tick from BaudRateGen.
- RX  in  1  asynchronous serial input, idle high.
- RX_DATA_OUT  out  DATA_WIDTH  last received byte.
- RX_DONE  out  1  one-CLK pulse when RX_DATA_OUT and the error flags update.
- PARITY_ERR  out  1  parity mismatch on the last frame.
- FRAME_ERR  out  1  stop bit sampled low on the last frame.
- State_dpg  out  3  debug: current state.
- bit_idx_dpg  out  $clog2(DATA_WIDTH)  debug: current data bit index.

Behaviour:
- Reset (async, RESET_N=0):
  - RX_DATA_OUT=0, RX_DONE=0, PARITY_ERR=0, FRAME_ERR=0, state IDLE, counters 0.
  - RX synchronizer flops = 1; armed flag = 1.
  - Takes effect immediately, including mid-frame.
- RX passes through a 2-FF synchronizer (2 CLK latency). All decisions use the synchronized value rx_s.
- tick_cnt (4 bits) and bit_idx advance only on CLK edges where RX_BR_TICKS=1.
- States and encoding (same as TRANSMITTER): IDLE=000, START=001, DATA=010, PARITY=011, STOP=100.
- IDLE:
  - rx_s=1 sets armed.
  - rx_s=0 with armed=1 -> START, tick_cnt=0.
- START:
  - On tick with tick_cnt=7 (mid start bit): rx_s=0 -> DATA, tick_cnt=0, bit_idx=0, and PARITY_EN/PARITY_MODE latched for the frame; rx_s=1 -> IDLE (glitch, no flags, no RX_DONE).
  - Otherwise tick_cnt++.
- DATA:
  - On tick with tick_cnt=15: shift rx_s into the MSB of the shift register (right shift, LSB first), tick_cnt=0.
  - If bit_idx=DATA_WIDTH-1 -> PARITY if the latched PARITY_EN=1, else STOP. Otherwise bit_idx++.
- PARITY:
  - On tick with tick_cnt=15: perr = ((^shift) ^ rx_s) != latched PARITY_MODE.
  - Then -> STOP, tick_cnt=0.
- STOP:
  - On tick with tick_cnt=STOP_BIT_TICKS-1 (use a counter wide enough for 32):
    - RX_DATA_OUT<=shift; RX_DONE<=1 for one CLK.
    - PARITY_ERR<=perr (0 if parity disabled); FRAME_ERR<=~rx_s.
    - -> IDLE.
  - If FRAME_ERR is set, armed<=0: a held-low line (break) does not start a new frame until rx_s has returned high.
- RX_DATA_OUT and the flags hold until the next RX_DONE. The data byte is delivered even when an error flag is set.
- Changing PARITY_EN/PARITY_MODE mid-frame has no effect until the next start bit.
- A tick coinciding with reset deassertion is ignored.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s at three sample points.
  - Start validation uses tick_cnt 5, 6, 7.
  - Data, parity and stop use tick_cnt 13, 14, 15; stop uses STOP_BIT_TICKS-3..-1.
- Undefined: single sample at tick_cnt 7 (start) or 15 (other bits). No extra sample registers.

Test Plan:
- 8'h55, PARITY_EN=0, 1 stop bit, 16 ticks per bit -> exactly one RX_DONE pulse ~152 ticks after the falling edge; RX_DATA_OUT=8'h55; PARITY_ERR=0; FRAME_ERR=0; State_dpg back to 000.
- PARITY_EN=1, PARITY_MODE=0, 8'hA5 with parity bit 0 -> RX_DATA_OUT=8'hA5, PARITY_ERR=0. Repeat with parity bit 1 -> PARITY_ERR=1, data still 8'hA5.
- 8'h3C with stop bit driven 0, line then held low 40 bit times -> RX_DONE once, FRAME_ERR=1, no further frames. Release high, send 8'h81 -> RX_DATA_OUT=8'h81, FRAME_ERR=0.
- RX low for 4 ticks then high -> START then IDLE, no RX_DONE, outputs unchanged.
- RESET_N pulsed low during data bit 3 -> State_dpg=000 and RX_DATA_OUT=0 immediately. Next frame 8'hF0 received correctly.
- 8'h00 with a 1-tick high glitch at tick 15 of bit 2 -> with UART_RX_MAJORITY_EN, RX_DATA_OUT=8'h00; without it, RX_DATA_OUT=8'h04.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 16x-oversampled frame recovery with parity/framing error flags.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around its sample point.
module uart_receiver #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned STOP_BIT_TICKS = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          PARITY_EN,
  input  logic                          PARITY_MODE,
  input  logic                          RX_BR_TICKS,
  input  logic                          RX,
  output logic [DATA_WIDTH-1:0]         RX_DATA_OUT,
  output logic                          RX_DONE,
  output logic                          PARITY_ERR,
  output logic                          FRAME_ERR,
  output logic [2:0]                    State_dpg,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx_dpg
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam int unsigned CntW = (STOP_BIT_TICKS > 16) ? $clog2(STOP_BIT_TICKS) : 4;

  localparam logic [CntW-1:0] StartLast = CntW'(7);
  localparam logic [CntW-1:0] BitLast   = CntW'(15);
  localparam logic [CntW-1:0] StopLast  = CntW'(STOP_BIT_TICKS - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StStart  = 3'b001,
    StData   = 3'b010,
    StParity = 3'b011,
    StStop   = 3'b100
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       tick_cnt_q;
  logic [IdxW-1:0]       bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_mode_q;
  logic                  perr_q;
  logic                  armed_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  perr_out_q;
  logic                  ferr_q;
  logic                  rx_meta_q;
  logic                  rx_s_q;
  logic                  bit_val;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0]      samp_q;
  logic [CntW-1:0] cur_last;

  always_comb begin
    cur_last = BitLast;
    if (state_q == StStart) begin
      cur_last = StartLast;
    end else if (state_q == StStop) begin
      cur_last = StopLast;
    end
  end

  // Two early samples feed the vote taken on the last tick of each bit window.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      samp_q <= 2'b11;
    end else if (RX_BR_TICKS && state_q != StIdle) begin
      if (tick_cnt_q == cur_last - CntW'(2)) samp_q[0] <= rx_s_q;
      if (tick_cnt_q == cur_last - CntW'(1)) samp_q[1] <= rx_s_q;
    end
  end

  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= 1'b0;
      perr_q     <= 1'b0;
      armed_q    <= 1'b1;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_s_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
          end
        end
        StStart: begin
          if (RX_BR_TICKS) begin
            if (tick_cnt_q == StartLast) begin
              tick_cnt_q <= '0;
              if (!bit_val) begin
                state_q    <= StData;
                bit_idx_q  <= '0;
                par_en_q   <= PARITY_EN;
                par_mode_q <= PARITY_MODE;
                perr_q     <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (RX_BR_TICKS) begin
            if (tick_cnt_q == BitLast) begin
              tick_cnt_q <= '0;
              shift_q    <= {bit_val, shift_q[DATA_WIDTH-1:1]};
              if (bit_idx_q == IdxLast) begin
                state_q <= par_en_q ? StParity : StStop;
              end else begin
                bit_idx_q <= bit_idx_q + IdxW'(1);
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        StParity: begin
          if (RX_BR_TICKS) begin
            if (tick_cnt_q == BitLast) begin
              tick_cnt_q <= '0;
              perr_q     <= ((^shift_q) ^ bit_val) != par_mode_q;
              state_q    <= StStop;
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        StStop: begin
          if (RX_BR_TICKS) begin
            if (tick_cnt_q == StopLast) begin
              tick_cnt_q <= '0;
              data_q     <= shift_q;
              done_q     <= 1'b1;
              perr_out_q <= perr_q & par_en_q;
              ferr_q     <= ~bit_val;
              // A break must return high before the next start bit is accepted.
              armed_q    <= bit_val;
              state_q    <= StIdle;
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          tick_cnt_q <= '0;
        end
      endcase
    end
  end

  assign RX_DATA_OUT = data_q;
  assign RX_DONE     = done_q;
  assign PARITY_ERR  = perr_out_q;
  assign FRAME_ERR   = ferr_q;
  assign State_dpg   = state_q;
  assign bit_idx_dpg = bit_idx_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scoreboard of expected frames checked on each RX_DONE.
module tb_uart_receiver;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       PARITY_EN = 1'b0;
  logic       PARITY_MODE = 1'b0;
  logic       RX_BR_TICKS = 1'b0;
  logic       RX = 1'b1;
  logic [7:0] RX_DATA_OUT;
  logic       RX_DONE;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic [2:0] State_dpg;
  logic [2:0] bit_idx_dpg;

  uart_receiver #(
    .DATA_WIDTH    (8),
    .STOP_BIT_TICKS(16)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .PARITY_EN  (PARITY_EN),
    .PARITY_MODE(PARITY_MODE),
    .RX_BR_TICKS(RX_BR_TICKS),
    .RX         (RX),
    .RX_DATA_OUT(RX_DATA_OUT),
    .RX_DONE    (RX_DONE),
    .PARITY_ERR (PARITY_ERR),
    .FRAME_ERR  (FRAME_ERR),
    .State_dpg  (State_dpg),
    .bit_idx_dpg(bit_idx_dpg)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  rec_t mon_o;
  int   checks = 0;
  int   failures = 0;
  int   tick_count = 0;
  int   done_cnt = 0;
  int   done_tick = 0;

  // One tick period = 3 CLKs; RX settles two CLKs before the tick so the synchronizer sees it.
  task automatic tick_period(input logic v);
    RX = v;
    repeat (2) @(negedge CLK);
    RX_BR_TICKS = 1'b1;
    tick_count++;
    @(negedge CLK);
    RX_BR_TICKS = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_period(1'b1);
  endtask

  task automatic send_bit(input logic v, input int glitch_off);
    for (int i = 0; i < 16; i++) tick_period((i == glitch_off) ? 1'b1 : v);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop_v, input int glitch_bit, input int glitch_off);
    send_bit(1'b0, -1);
    for (int b = 0; b < 8; b++) send_bit(d[b], (b == glitch_bit) ? glitch_off : -1);
    if (par_en) send_bit(par_bit, -1);
    send_bit(stop_v, -1);
  endtask

  always @(negedge CLK) begin
    if (RX_DONE === 1'b1) begin
      done_cnt++;
      done_tick = tick_count;
      checks++;
      mon_o = {RX_DATA_OUT, PARITY_ERR, FRAME_ERR};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rx_done_unexpected: got data=%h perr=%b ferr=%b, required no RX_DONE",
                 RX_DATA_OUT, PARITY_ERR, FRAME_ERR);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          failures++;
          $display("FAIL rx_frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   mon_o.data, mon_o.perr, mon_o.ferr, mon_e.data, mon_e.perr, mon_e.ferr);
        end
      end
    end
  end

  task automatic test_reset();
    #2 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({RX_DATA_OUT, RX_DONE, PARITY_ERR, FRAME_ERR} !== 11'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {RX_DATA_OUT, RX_DONE, PARITY_ERR, FRAME_ERR});
    end
    checks++;
    if ({State_dpg, bit_idx_dpg} !== 6'h0) begin
      failures++;
      $display("FAIL reset_state: got state=%b idx=%0d, required 000/0", State_dpg, bit_idx_dpg);
    end
    RESET_N = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int t0;
    int d0;
    PARITY_EN = 1'b0;
    t0 = tick_count;
    d0 = done_cnt;
    exp_q.push_back({8'h55, 1'b0, 1'b0});
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(4);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL basic_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
    // Falling edge shares tick 0; start mid-point is tick 8, stop sample 144 ticks later.
    checks++;
    if (done_tick - t0 != 153) begin
      failures++;
      $display("FAIL basic_latency: got tick %0d, required 153", done_tick - t0);
    end
    checks++;
    if (State_dpg !== 3'b000) begin
      failures++;
      $display("FAIL basic_state: got %b, required 000", State_dpg);
    end
  endtask

  task automatic test_parity();
    PARITY_EN = 1'b1;
    PARITY_MODE = 1'b0;
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, -1);
    exp_q.push_back({8'hA5, 1'b1, 1'b0});
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, -1);
    PARITY_MODE = 1'b1;
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, -1);
    idle(4);
    PARITY_EN = 1'b0;
    PARITY_MODE = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL parity_missing: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_break();
    int d0;
    d0 = done_cnt;
    exp_q.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 640; i++) tick_period(1'b0);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL break_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
    checks++;
    if (State_dpg !== 3'b000) begin
      failures++;
      $display("FAIL break_state: got %b, required 000", State_dpg);
    end
    checks++;
    if ({RX_DATA_OUT, FRAME_ERR} !== {8'h3C, 1'b1}) begin
      failures++;
      $display("FAIL break_hold: got data=%h ferr=%b, required 3c/1", RX_DATA_OUT, FRAME_ERR);
    end
    idle(16);
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL break_recover_missing: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_start_glitch();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) tick_period(1'b0);
    checks++;
    if (State_dpg !== 3'b001) begin
      failures++;
      $display("FAIL glitch_start_state: got %b, required 001", State_dpg);
    end
    idle(16);
    checks++;
    if (State_dpg !== 3'b000) begin
      failures++;
      $display("FAIL glitch_idle_state: got %b, required 000", State_dpg);
    end
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL glitch_done: got %0d pulses, required 0", done_cnt - d0);
    end
    checks++;
    if ({RX_DATA_OUT, PARITY_ERR, FRAME_ERR} !== {8'h81, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL glitch_hold: got data=%h perr=%b ferr=%b, required 81/0/0",
               RX_DATA_OUT, PARITY_ERR, FRAME_ERR);
    end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, -1);
    for (int b = 0; b < 3; b++) send_bit(1'b1, -1);
    for (int i = 0; i < 8; i++) tick_period(1'b1);
    checks++;
    if ({State_dpg, bit_idx_dpg} !== {3'b010, 3'd3}) begin
      failures++;
      $display("FAIL midframe_state: got state=%b idx=%0d, required 010/3", State_dpg, bit_idx_dpg);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({State_dpg, RX_DATA_OUT} !== 11'h0) begin
      failures++;
      $display("FAIL async_reset: got state=%b data=%h, required 000/00", State_dpg, RX_DATA_OUT);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    idle(16);
    exp_q.push_back({8'hF0, 1'b0, 1'b0});
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_missing: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_data_glitch();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h00;
`else
    exp_d = 8'h04;
`endif
    exp_q.push_back({exp_d, 1'b0, 1'b0});
    // Offset 8 within bench bit 2 is the receiver's last sample tick of that bit.
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 2, 8);
    idle(4);
    checks++;
    if (exp_q.size() != 0 || RX_DATA_OUT !== exp_d) begin
      failures++;
      $display("FAIL data_glitch: got data=%h outstanding=%0d, required %h/0",
               RX_DATA_OUT, exp_q.size(), exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_start_glitch();
    test_reset_mid();
    test_data_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
